// File: rtl/axi_sram_responder.sv
// AXI3-style single-outstanding slave backed by a word-addressed internal memory.
// Supports FIXED/INCR/WRAP bursts of 1-16 beats, byte strobes and ID echo.
module axi_sram_responder #(
    parameter int unsigned MEM_ADDR_WIDTH = 12
) (
    input  logic        aclk,
    input  logic        resetn,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int unsigned Depth = 1 << MEM_ADDR_WIDTH;

    typedef enum logic [1:0] {StIdle, StRead, StWdata, StWresp} state_e;

    state_e      state_q, state_d;
    logic        prio_q, prio_d;  // 0: read wins a tie, 1: write wins
    logic [3:0]  id_q, id_d;
    logic [3:0]  len_q, len_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  burst_q, burst_d;
    logic [31:0] addr_q, addr_d;

    logic [31:0] mem [Depth];
    logic [MEM_ADDR_WIDTH-1:0] idx;
    logic [31:0] next_addr;
    logic [31:0] wrap_mask;
    logic        wrap_ok;
    logic        ar_hs, aw_hs, r_hs, w_hs;
    logic        unused_wlast;

    // Burst length comes from the beat counter; the master's wlast is informational only.
    assign unused_wlast = wlast;

    assign idx = addr_q[MEM_ADDR_WIDTH+1:2];

    always_comb begin
        wrap_ok   = (len_q == 4'd1) || (len_q == 4'd3) || (len_q == 4'd7) || (len_q == 4'd15);
        wrap_mask = ((32'(len_q) + 32'd1) << 2) - 32'd1;
        next_addr = addr_q + 32'd4;
        if (burst_q == 2'b00) begin
            next_addr = addr_q;
        end else if (burst_q == 2'b10 && wrap_ok) begin
            next_addr = (addr_q & ~wrap_mask) | ((addr_q + 32'd4) & wrap_mask);
        end
    end

    assign arready = resetn && (state_q == StIdle) && (!awvalid || !prio_q);
    assign awready = resetn && (state_q == StIdle) && (!arvalid || prio_q);
    assign rvalid  = (state_q == StRead);
    assign wready  = (state_q == StWdata);
    assign bvalid  = (state_q == StWresp);
    assign rid     = id_q;
    assign bid     = id_q;
    assign rresp   = 2'b00;
    assign bresp   = 2'b00;
    assign rdata   = mem[idx];
    assign rlast   = rvalid && (cnt_q == len_q);

    assign ar_hs = arvalid && arready;
    assign aw_hs = awvalid && awready;
    assign r_hs  = rvalid && rready;
    assign w_hs  = wvalid && wready;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        id_d    = id_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        burst_d = burst_q;
        addr_d  = addr_q;
        case (state_q)
            StIdle: begin
                if (ar_hs) begin
                    {id_d, addr_d, len_d, burst_d} = {arid, araddr, arlen, arburst};
                    cnt_d   = 4'd0;
                    prio_d  = 1'b1;
                    state_d = StRead;
                end else if (aw_hs) begin
                    {id_d, addr_d, len_d, burst_d} = {awid, awaddr, awlen, awburst};
                    cnt_d   = 4'd0;
                    prio_d  = 1'b0;
                    state_d = StWdata;
                end
            end
            StRead: begin
                if (r_hs) begin
                    if (cnt_q == len_q) begin
                        cnt_d   = 4'd0;
                        state_d = StIdle;
                    end else begin
                        cnt_d  = cnt_q + 4'd1;
                        addr_d = next_addr;
                    end
                end
            end
            StWdata: begin
                if (w_hs) begin
                    if (cnt_q == len_q) begin
                        cnt_d   = 4'd0;
                        state_d = StWresp;
                    end else begin
                        cnt_d  = cnt_q + 4'd1;
                        addr_d = next_addr;
                    end
                end
            end
            StWresp: begin
                if (bready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            prio_q  <= 1'b0;
            id_q    <= 4'd0;
            len_q   <= 4'd0;
            cnt_q   <= 4'd0;
            burst_q <= 2'b00;
            addr_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            id_q    <= id_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            burst_q <= burst_d;
            addr_q  <= addr_d;
        end
    end

    // Memory has no reset: partial bursts survive a mid-transaction reset.
    always_ff @(posedge aclk) begin
        if (w_hs) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_responder.sv
// Randomized scoreboard bench for axi_sram_responder against a byte-level memory model.
module tb_axi_sram_responder;

    localparam int AW = 12;

    logic        aclk = 1'b0;
    logic        resetn;
    logic [3:0]  arid, awid, rid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [3:0]  arlen, awlen, wstrb;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    always #5 aclk = ~aclk;

    axi_sram_responder #(.MEM_ADDR_WIDTH(AW)) dut (
        .aclk(aclk), .resetn(resetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  id;
        logic        last;
    } rbeat_t;

    int          total = 0;
    int          bad = 0;
    logic [31:0] model [1 << AW];
    rbeat_t      exp_r [$];
    logic [3:0]  exp_b [$];
    logic        exp_prio;
    logic [31:0] wbuf [16];
    logic [3:0]  sbuf [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic int unsigned widx(input logic [31:0] a);
        return 32'(a[AW+1:2]);
    endfunction

    // Address of beat k from the burst rules: wrap within an aligned block of (len+1) words.
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [3:0] len,
                                              input logic [1:0] burst, input int k);
        logic [31:0] size, base;
        if (burst == 2'b00) return start;
        if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            size = (32'(len) + 32'd1) * 32'd4;
            base = start - (start % size);
            return base + ((start - base + 32'(4 * k)) % size);
        end
        return start + 32'(4 * k);
    endfunction

    function automatic logic [31:0] rand_addr();
        return {18'($urandom), 12'($urandom_range(0, 239)), 2'($urandom)};
    endfunction

    // Monitor: pops expected beats/responses whenever the DUT presents them.
    rbeat_t      mon_b;
    logic        stall_q = 1'b0;
    logic [31:0] held;
    always @(negedge aclk) begin
        if (!resetn) begin
            stall_q = 1'b0;
        end else begin
            if (rvalid) begin
                if (stall_q) check("r_stable", rdata, held);
                if (rready) begin
                    if (exp_r.size() == 0) begin
                        check("r_unexpected", 32'(rvalid), 32'd0);
                    end else begin
                        mon_b = exp_r.pop_front();
                        check("rdata", rdata, mon_b.data);
                        check("rid", 32'(rid), 32'(mon_b.id));
                        check("rlast", 32'(rlast), 32'(mon_b.last));
                        check("rresp", 32'(rresp), 32'd0);
                    end
                end
                stall_q = !rready;
                held = rdata;
            end else begin
                stall_q = 1'b0;
            end
            if (bvalid && bready) begin
                if (exp_b.size() == 0) begin
                    check("b_unexpected", 32'(bvalid), 32'd0);
                end else begin
                    check("bid", 32'(bid), 32'(exp_b.pop_front()));
                    check("bresp", 32'(bresp), 32'd0);
                end
            end
        end
    end

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input bit rand_ready, input bit chk_ar);
        rbeat_t e;
        int n;
        for (int k = 0; k <= int'(len); k++) begin
            e.data = model[widx(beat_addr(addr, len, burst, k))];
            e.id   = id;
            e.last = (k == int'(len));
            exp_r.push_back(e);
        end
        tick();
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        for (n = 0; n < 100; n++) begin
            @(negedge aclk);
            if (arready) break;
        end
        check("ar_grant", 32'(arready), 32'd1);
        tick();
        arvalid  = 1'b0;
        exp_prio = 1'b1;
        rready   = rand_ready ? 1'($urandom) : 1'b1;
        @(negedge aclk);
        check("r_first", 32'(rvalid), 32'd1);
        for (n = 0; n < 400 && exp_r.size() != 0; n++) begin
            tick();
            rready = rand_ready ? 1'($urandom) : 1'b1;
            @(negedge aclk);
            if (chk_ar && exp_r.size() != 0) check("ar_blocked", 32'(arready), 32'd0);
        end
        tick();
        rready = 1'b0;
        check("r_drain", 32'(exp_r.size()), 32'd0);
        exp_r.delete();
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input bit rand_gap);
        int n;
        int unsigned a;
        tick();
        awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        for (n = 0; n < 100; n++) begin
            @(negedge aclk);
            if (awready) break;
        end
        check("aw_grant", 32'(awready), 32'd1);
        tick();
        awvalid  = 1'b0;
        exp_prio = 1'b0;
        @(negedge aclk);
        check("w_first", 32'(wready), 32'd1);
        for (int k = 0; k <= int'(len); k++) begin
            tick();
            if (rand_gap && $urandom_range(0, 2) == 0) begin
                wvalid = 1'b0;
                tick();
            end
            wvalid = 1'b1; wdata = wbuf[k]; wstrb = sbuf[k]; wlast = (k == int'(len));
            for (n = 0; n < 50; n++) begin
                @(negedge aclk);
                if (wready) break;
            end
            check("w_ready", 32'(wready), 32'd1);
            a = widx(beat_addr(addr, len, burst, k));
            for (int b = 0; b < 4; b++) if (sbuf[k][b]) model[a][8*b +: 8] = wbuf[k][8*b +: 8];
        end
        tick();
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
        exp_b.push_back(id);
        @(negedge aclk);
        check("b_rise", 32'(bvalid), 32'd1);
        for (n = 0; n < 100 && exp_b.size() != 0; n++) begin
            tick();
            bready = rand_gap ? 1'($urandom) : 1'b1;
            @(negedge aclk);
        end
        tick();
        bready = 1'b0;
        check("b_drain", 32'(exp_b.size()), 32'd0);
        exp_b.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr;
        logic [3:0]  len;
        logic [1:0]  burst;
        int          saw_b;

        resetn = 1'b0;
        {arid, araddr, arlen, arburst, arvalid, rready} = '0;
        {awid, awaddr, awlen, awburst, awvalid} = '0;
        {wdata, wstrb, wlast, wvalid, bready} = '0;
        repeat (3) tick();
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        resetn   = 1'b1;
        exp_prio = 1'b0;
        @(negedge aclk);
        check("idle_arready", 32'(arready), 32'd1);
        check("idle_awready", 32'(awready), 32'd1);

        // Fill words 0..255 so every later read has a defined model value.
        for (int blk = 0; blk < 16; blk++) begin
            for (int k = 0; k < 16; k++) begin wbuf[k] = $urandom; sbuf[k] = 4'hf; end
            do_write(4'($urandom), 32'(blk * 64), 4'd15, 2'b01, 1'b0);
        end

        for (int k = 0; k < 4; k++) begin wbuf[k] = 32'h11111111 * 32'(k + 1); sbuf[k] = 4'hf; end
        do_write(4'h5, 32'h100, 4'd3, 2'b01, 1'b0);
        do_read(4'h9, 32'h100, 4'd3, 2'b01, 1'b0, 1'b0);

        wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'hf;
        do_write(4'h1, 32'h200, 4'd0, 2'b01, 1'b0);
        wbuf[0] = 32'h12345678; sbuf[0] = 4'b0101;
        do_write(4'h2, 32'h200, 4'd0, 2'b01, 1'b0);
        do_read(4'h3, 32'h200, 4'd0, 2'b01, 1'b0, 1'b0);

        do_read(4'h4, 32'h3C, 4'd3, 2'b10, 1'b0, 1'b0);
        do_read(4'h6, 32'h40, 4'd2, 2'b00, 1'b0, 1'b0);
        do_read(4'h7, 32'h80, 4'd15, 2'b01, 1'b1, 1'b1);

        for (int t = 0; t < 30; t++) begin
            addr  = rand_addr();
            len   = 4'($urandom);
            burst = 2'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                do_read(4'($urandom), addr, len, burst, 1'b1, 1'b0);
            end else begin
                for (int k = 0; k < 16; k++) begin wbuf[k] = $urandom; sbuf[k] = 4'($urandom); end
                do_write(4'($urandom), addr, len, burst, 1'b1);
            end
        end

        // Simultaneous requests: the granted side must alternate.
        for (int r = 0; r < 4; r++) begin
            tick();
            arid = 4'($urandom); araddr = rand_addr(); arlen = 4'($urandom_range(0, 3));
            arburst = 2'b01;
            awid = 4'($urandom); awaddr = rand_addr(); awlen = 4'($urandom_range(0, 3));
            awburst = 2'b01;
            arvalid = 1'b1; awvalid = 1'b1;
            @(negedge aclk);
            check("arb_ar", 32'(arready), 32'(exp_prio == 1'b0));
            check("arb_aw", 32'(awready), 32'(exp_prio == 1'b1));
            arvalid = 1'b0; awvalid = 1'b0;
            if (exp_prio == 1'b0) begin
                do_read(arid, araddr, arlen, arburst, 1'b1, 1'b0);
            end else begin
                for (int k = 0; k < 16; k++) begin wbuf[k] = $urandom; sbuf[k] = 4'($urandom); end
                do_write(awid, awaddr, awlen, awburst, 1'b1);
            end
        end

        // Reset in the middle of an 8-beat write after 3 beats.
        tick();
        awid = 4'hA; awaddr = 32'h300; awlen = 4'd7; awburst = 2'b01; awvalid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge aclk);
            if (awready) break;
        end
        check("rst_aw_grant", 32'(awready), 32'd1);
        tick();
        awvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            wvalid = 1'b1; wdata = $urandom; wstrb = 4'hf; wlast = 1'b0;
            @(negedge aclk);
            check("rst_w_ready", 32'(wready), 32'd1);
            model[widx(32'h300) + 32'(k)] = wdata;
        end
        tick();
        wvalid = 1'b0;
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_wready", 32'(wready), 32'd0);
        check("mid_rst_bvalid", 32'(bvalid), 32'd0);
        check("mid_rst_rvalid", 32'(rvalid), 32'd0);
        check("mid_rst_arready", 32'(arready), 32'd0);
        check("mid_rst_awready", 32'(awready), 32'd0);
        tick();
        tick();
        resetn   = 1'b1;
        exp_prio = 1'b0;
        saw_b    = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge aclk);
            if (bvalid) saw_b++;
        end
        check("no_bresp", 32'(saw_b), 32'd0);
        check("post_rst_arready", 32'(arready), 32'd1);
        check("post_rst_awready", 32'(awready), 32'd1);
        do_read(4'hB, 32'h300, 4'd7, 2'b01, 1'b0, 1'b0);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
